// File: rtl/branch_seq_ctrl_pkg.sv
// branch_seq_ctrl_pkg: opcode/funct/REGIMM codes, FSM states and transfer kinds
package branch_seq_ctrl_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;
  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, COMMIT = 2'd2} state_t;
  typedef enum logic [1:0] {K_BRANCH = 2'd0, K_JUMP = 2'd1, K_JREG = 2'd2, K_ILLEGAL = 2'd3} kind_t;
endpackage

// File: rtl/branch_seq_ctrl_cond.sv
// branch_cond_eval: conditional-branch decode and condition evaluation
module branch_cond_eval
  import branch_seq_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rt_field,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        taken,
  output logic        is_cond
);
  logic rs_neg, rs_zero, regimm_ok;
  always_comb begin
    rs_neg = rs[31];
    rs_zero = rs == 32'd0;
    regimm_ok = op == OP_REGIMM && (rt_field inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL});
    is_cond = regimm_ok || (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ});
    taken = op == OP_BEQ ? rs == rt :
            op == OP_BNE ? rs != rt :
            op == OP_BLEZ ? rs_neg || rs_zero :
            op == OP_BGTZ ? !rs_neg && !rs_zero :
            regimm_ok && (rt_field[0] ? !rs_neg : rs_neg);
  end
endmodule

// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: three-state sequencer for branches, jumps and register jumps
module branch_seq_ctrl
  import branch_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [4:0]       rt_field,
  input  logic [4:0]       rd_field,
  input  logic [5:0]       funct,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jtarget,
  input  logic [31:0]      pc_plus4,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic             busy,
  output logic             done,
  output logic             pc_write,
  output logic [31:0]      pc_next,
  output logic             link_write,
  output logic [4:0]       link_reg,
  output logic [31:0]      link_val,
  output logic             illegal,
  output logic             addr_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_t state, state_nx;
  kind_t kind_q, kind_d;
  logic [5:0] op_q, funct_q;
  logic [4:0] rtf_q, rdf_q, link_reg_q;
  logic [15:0] imm_q;
  logic [25:0] jt_q;
  logic [31:0] pc4_q, rs_q, rt_q, target_q, target_d;
  logic taken_q, link_q, taken_d, is_cond, is_jalr, link_d, commit, mis;
  branch_cond_eval u_cond (
    .op(op_q), .rt_field(rtf_q), .rs(rs_q), .rt(rt_q), .taken(taken_d), .is_cond(is_cond)
  );
  always_comb begin
    state_nx = state == IDLE ? (start ? EVAL : IDLE) : state == EVAL ? COMMIT : IDLE;
    is_jalr = op_q == OP_SPECIAL && funct_q == FN_JALR;
    kind_d = is_cond ? K_BRANCH :
             (op_q == OP_J || op_q == OP_JAL) ? K_JUMP :
             (op_q == OP_SPECIAL && (funct_q == FN_JR || is_jalr)) ? K_JREG : K_ILLEGAL;
    target_d = kind_d == K_JREG ? rs_q :
               kind_d == K_JUMP ? {pc4_q[31:28], jt_q, 2'b00} :
               pc4_q + {{14{imm_q[15]}}, imm_q, 2'b00};
    link_d = op_q == OP_JAL || is_jalr || (is_cond && op_q == OP_REGIMM && rtf_q[4]);
    commit = state == COMMIT;
    mis = kind_q == K_JREG && target_q[1:0] != 2'b00;
    busy = state != IDLE;
    done = commit;
    pc_write = commit && (kind_q == K_JUMP || (kind_q == K_JREG && !mis) || (kind_q == K_BRANCH && taken_q));
    link_write = commit && link_q && !mis;
    illegal = commit && kind_q == K_ILLEGAL;
    addr_err = commit && mis;
    pc_next = target_q;
    link_reg = link_reg_q;
    link_val = pc4_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {op_q, rtf_q, rdf_q, funct_q, imm_q, jt_q, pc4_q, rs_q, rt_q} <= '0;
      {taken_q, link_q, link_reg_q, target_q} <= '0;
      kind_q <= K_BRANCH;
      branch_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start)
        {op_q, rtf_q, rdf_q, funct_q, imm_q, jt_q, pc4_q, rs_q, rt_q} <=
          {op, rt_field, rd_field, funct, imm16, jtarget, pc_plus4, rs_val, rt_val};
      if (state == EVAL) begin
        taken_q <= taken_d;
        kind_q <= kind_d;
        target_q <= target_d;
        link_q <= link_d;
        link_reg_q <= is_jalr ? rdf_q : 5'd31;
      end
      if (commit && kind_q == K_BRANCH) begin
        if (~&branch_cnt) branch_cnt <= branch_cnt + CNT_W'(1);
        if (taken_q && ~&taken_cnt) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_seq_ctrl.sv
// tb_branch_seq_ctrl: directed vector table plus multi-cycle corner sequences
module tb_branch_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic [4:0] rt_field = '0, rd_field = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] jtarget = '0;
  logic [31:0] pc_plus4 = '0, rs_val = '0, rt_val = '0;
  logic busy, done, pc_write, link_write, illegal, addr_err;
  logic [31:0] pc_next, link_val;
  logic [4:0] link_reg;
  logic [15:0] branch_cnt, taken_cnt;
  logic busy2, done2, pcw2, lw2, ill2, aerr2;
  logic [31:0] nxt2, lv2;
  logic [4:0] lr2;
  logic [1:0] bc2, tc2;
  int checks = 0, failures = 0;
  int exp_bc = 0, exp_tc = 0;
  always #5 clk = ~clk;
  branch_seq_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rt_field(rt_field), .rd_field(rd_field),
    .funct(funct), .imm16(imm16), .jtarget(jtarget), .pc_plus4(pc_plus4), .rs_val(rs_val),
    .rt_val(rt_val), .busy(busy), .done(done), .pc_write(pc_write), .pc_next(pc_next),
    .link_write(link_write), .link_reg(link_reg), .link_val(link_val), .illegal(illegal),
    .addr_err(addr_err), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );
  branch_seq_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .rt_field(rt_field), .rd_field(rd_field),
    .funct(funct), .imm16(imm16), .jtarget(jtarget), .pc_plus4(pc_plus4), .rs_val(rs_val),
    .rt_val(rt_val), .busy(busy2), .done(done2), .pc_write(pcw2), .pc_next(nxt2),
    .link_write(lw2), .link_reg(lr2), .link_val(lv2), .illegal(ill2),
    .addr_err(aerr2), .branch_cnt(bc2), .taken_cnt(tc2)
  );
  typedef struct {
    logic [5:0] op;
    logic [4:0] rtf;
    logic [4:0] rdf;
    logic [5:0] fn;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [31:0] rt;
    logic pcw;
    logic [31:0] nxt;
    logic chk_nxt;
    logic lw;
    logic [4:0] lr;
    logic ill;
    logic aerr;
    logic br;
    logic tk;
  } vec_t;
  vec_t vecs[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    op = v.op; rt_field = v.rtf; rd_field = v.rdf; funct = v.fn; imm16 = v.imm;
    jtarget = v.jt; pc_plus4 = v.pc4; rs_val = v.rs; rt_val = v.rt;
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    apply(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_busy_eval", idx), {31'd0, busy}, 32'd1);
    chk($sformatf("v%0d_done_early", idx), {31'd0, done}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_pc_write", idx), {31'd0, pc_write}, {31'd0, v.pcw});
    if (v.chk_nxt) chk($sformatf("v%0d_pc_next", idx), pc_next, v.nxt);
    chk($sformatf("v%0d_link_write", idx), {31'd0, link_write}, {31'd0, v.lw});
    if (v.lw) chk($sformatf("v%0d_link_reg", idx), {27'd0, link_reg}, {27'd0, v.lr});
    chk($sformatf("v%0d_link_val", idx), link_val, v.pc4);
    chk($sformatf("v%0d_illegal", idx), {31'd0, illegal}, {31'd0, v.ill});
    chk($sformatf("v%0d_addr_err", idx), {31'd0, addr_err}, {31'd0, v.aerr});
    if (v.br) exp_bc++;
    if (v.br && v.tk) exp_tc++;
    @(negedge clk);
    chk($sformatf("v%0d_busy_idle", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d_done_after", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d_branch_cnt", idx), {16'd0, branch_cnt}, exp_bc);
    chk($sformatf("v%0d_taken_cnt", idx), {16'd0, taken_cnt}, exp_tc);
  endtask
  initial begin
    vecs[0]  = '{6'h04, 5'h00, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h100, 32'd5, 32'd5,
                 1'b1, 32'h110, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{6'h07, 5'h00, 5'd0, 6'h00, 16'hFFFF, 26'h0, 32'h100, 32'h80000000, 32'd0,
                 1'b0, 32'h0FC, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{6'h00, 5'h00, 5'd9, 6'h09, 16'h0000, 26'h0, 32'h40, 32'h2000, 32'd0,
                 1'b1, 32'h2000, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{6'h00, 5'h00, 5'd9, 6'h09, 16'h0000, 26'h0, 32'h40, 32'h2002, 32'd0,
                 1'b0, 32'h0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6'h23, 5'h00, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h100, 32'd5, 32'd5,
                 1'b0, 32'h0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'h05, 5'h00, 5'd0, 6'h00, 16'h0010, 26'h0, 32'h200, 32'd1, 32'd2,
                 1'b1, 32'h240, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{6'h02, 5'h00, 5'd0, 6'h00, 16'h0000, 26'h0000040, 32'hA0000000, 32'd0, 32'd0,
                 1'b1, 32'hA0000100, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'h03, 5'h00, 5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h10000004, 32'd0, 32'd0,
                 1'b1, 32'h1FFFFFFC, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'h01, 5'h10, 5'd0, 6'h00, 16'h0008, 26'h0, 32'h300, 32'd5, 32'd0,
                 1'b0, 32'h320, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{6'h01, 5'h11, 5'd0, 6'h00, 16'hFFFE, 26'h0, 32'h300, 32'd0, 32'd0,
                 1'b1, 32'h2F8, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{6'h06, 5'h00, 5'd0, 6'h00, 16'h0001, 26'h0, 32'hFFFFFFFC, 32'd0, 32'd0,
                 1'b1, 32'h0, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{6'h01, 5'h02, 5'd0, 6'h00, 16'h0001, 26'h0, 32'h100, 32'd0, 32'd0,
                 1'b0, 32'h0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{6'h00, 5'h00, 5'd3, 6'h20, 16'h0000, 26'h0, 32'h100, 32'h1000, 32'd0,
                 1'b0, 32'h0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{6'h01, 5'h00, 5'd0, 6'h00, 16'h8000, 26'h0, 32'h00020000, 32'hFFFFFFFF, 32'd0,
                 1'b1, 32'h0, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{6'h00, 5'h00, 5'd0, 6'h08, 16'h0000, 26'h0, 32'h80, 32'h1234, 32'd0,
                 1'b1, 32'h1234, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{6'h01, 5'h01, 5'd0, 6'h00, 16'h0004, 26'h0, 32'h500, 32'h80000000, 32'd0,
                 1'b0, 32'h510, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);
    chk("rst_link_val", link_val, 32'd0);
    chk("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);
    @(negedge clk);
    apply(vecs[5]);
    start = 1'b1;
    @(negedge clk);
    chk("hold_busy_eval0", {31'd0, busy}, 32'd1);
    chk("hold_done_eval0", {31'd0, done}, 32'd0);
    rt_val = 32'd1;
    @(negedge clk);
    chk("hold_done_commit0", {31'd0, done}, 32'd1);
    chk("hold_pcw_commit0", {31'd0, pc_write}, 32'd1);
    rt_val = 32'd2;
    @(negedge clk);
    chk("hold_busy_idle", {31'd0, busy}, 32'd0);
    chk("hold_done_idle", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("hold_busy_eval1", {31'd0, busy}, 32'd1);
    chk("hold_done_eval1", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_done_commit1", {31'd0, done}, 32'd1);
    chk("hold_pcw_commit1", {31'd0, pc_write}, 32'd1);
    chk("hold_pc_next1", pc_next, 32'h240);
    exp_bc += 2;
    exp_tc += 2;
    @(negedge clk);
    chk("hold_busy_end", {31'd0, busy}, 32'd0);
    chk("hold_branch_cnt", {16'd0, branch_cnt}, exp_bc);
    chk("hold_taken_cnt", {16'd0, taken_cnt}, exp_tc);
    @(negedge clk);
    apply(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_eval_busy", {31'd0, busy}, 32'd0);
    chk("rst_eval_done", {31'd0, done}, 32'd0);
    chk("rst_eval_pcw", {31'd0, pc_write}, 32'd0);
    chk("rst_eval_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    chk("rst_eval_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    exp_bc = 0;
    exp_tc = 0;
    @(negedge clk);
    chk("rst_eval_done_after", {31'd0, done}, 32'd0);
    chk("rst_eval_busy_after", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) run_vec(vecs[0], 100 + i);
    chk("sat_branch_cnt", {30'd0, bc2}, 32'd3);
    chk("sat_taken_cnt", {30'd0, tc2}, 32'd3);
    run_vec(vecs[1], 200);
    chk("sat_branch_hold", {30'd0, bc2}, 32'd3);
    chk("sat_taken_hold", {30'd0, tc2}, 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
